// File: rtl/diff_pkg.sv
// Shared definitions for the Manchester link (transmitter and receiver).
package diff_pkg;

   // Receiver frame-tracking states.
   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      BIT       = 3'd2,
      DONE      = 3'd3,
      WAIT_IDLE = 3'd4
   } rx_state_t;

   // Payload bits per frame.
   localparam int FRAME_BITS = 26;

   // Default clocks per bit period, shared with the transmitter.
   localparam int DATA_PERIOD = 20;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous line, reset to 0.
module sync_2ff (
   input  logic clk_in,
   input  logic rst_in,
   input  logic d_i,
   output logic q_o
);

   logic s1_q;
   logic s2_q;

   // Two-stage capture to settle metastability before use.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
      end
   end

   assign q_o = s2_q;

endmodule

// File: rtl/diff_rx.sv
// Manchester line receiver: start-symbol detect, mid-half sampling, word
// assembly MSB first, one-cycle valid/error strobes.
module diff_rx
   import diff_pkg::*;
#(
   parameter int DATA_PERIOD = diff_pkg::DATA_PERIOD,
   parameter int DATA_WIDTH  = FRAME_BITS
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  error_out,
   output logic                  busy_out
);

   localparam int CW = $clog2(DATA_PERIOD);
   localparam int IW = $clog2(DATA_WIDTH);

   // Counter landmarks within one bit period.
   localparam logic [CW-1:0] C_Q1   = CW'(DATA_PERIOD / 4);
   localparam logic [CW-1:0] C_HALF = CW'(DATA_PERIOD / 2);
   localparam logic [CW-1:0] C_Q3   = CW'(3 * DATA_PERIOD / 4);
   localparam logic [CW-1:0] C_LAST = CW'(DATA_PERIOD - 1);
   localparam logic [IW-1:0] I_TOP  = IW'(DATA_WIDTH - 1);

   logic                  sync;
   logic                  prev_q;
   rx_state_t             state_q,  state_d;
   logic [CW-1:0]         cnt_q,    cnt_d;
   logic [IW-1:0]         idx_q,    idx_d;
   logic                  h1_q,     h1_d;
   logic [DATA_WIDTH-1:0] shift_q,  shift_d;
   logic [DATA_WIDTH-1:0] data_q,   data_d;
   logic                  valid_q,  valid_d;
   logic                  error_q,  error_d;

   sync_2ff u_sync (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .d_i    (data_in),
      .q_o    (sync)
   );

   // State, counters, shift register and output strobes.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         prev_q  <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         h1_q    <= 1'b0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         prev_q  <= sync;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         h1_q    <= h1_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         error_q <= error_d;
      end
   end

   // Next-state logic: track the frame and decode each Manchester cell.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      h1_d    = h1_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      error_d = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (sync && !prev_q) state_d = START;
         end

         START: begin
            // A start symbol must still be high at mid-period; otherwise
            // it was a glitch and is dropped without an error.
            if (cnt_q == C_HALF && !sync) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == C_LAST) begin
               cnt_d   = '0;
               idx_d   = I_TOP;
               state_d = BIT;
            end
         end

         BIT: begin
            if (cnt_q == C_Q1) h1_d = sync;
            if (cnt_q == C_Q3) begin
               if (h1_q == sync) begin
                  // No mid-cell transition: not a valid Manchester symbol.
                  error_d = 1'b1;
                  state_d = WAIT_IDLE;
                  cnt_d   = '0;
               end else begin
                  shift_d = {shift_q[DATA_WIDTH-2:0], h1_q};
               end
            end else if (cnt_q == C_LAST) begin
               if (idx_q == '0) begin
                  state_d = DONE;
               end else begin
                  idx_d = idx_q - 1'b1;
                  cnt_d = '0;
               end
            end
         end

         DONE: begin
            data_d  = shift_q;
            valid_d = 1'b1;
            cnt_d   = '0;
            state_d = WAIT_IDLE;
         end

         WAIT_IDLE: begin
            // Hold off until the line is low so the trailing high half of
            // a final 0 bit is not mistaken for a new start symbol.
            cnt_d = '0;
            if (!sync) state_d = IDLE;
         end

         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign data_out  = data_q;
   assign valid_out = valid_q;
   assign error_out = error_q;
   assign busy_out  = (state_q != IDLE);

endmodule
